// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Register map, CTRL bit positions and hex segment table for
//               the multiplexed seven-segment controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [31:0] c_off_ctrl    = 32'h0000_0000;
    localparam logic [31:0] c_off_compare = 32'h0000_0004;
    localparam logic [31:0] c_off_direct  = 32'h0000_0008;
    localparam logic [31:0] c_off_count   = 32'h0000_000C;

    localparam int c_ctrl_active   = 0;
    localparam int c_ctrl_soft_rst = 1;
    localparam int c_ctrl_direct   = 2;
    localparam int c_ctrl_blank    = 3;

    // Segment order {g,f,e,d,c,b,a}; entry 0 sits in the low slice.
    localparam logic [15:0][6:0] c_seg_table = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return c_seg_table[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decode
// Description : Combinational 4-bit hex to active-high seven-segment lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_wrapper
// Description : Wishbone-controlled N-digit BCD seconds counter / hex display
//               with time-multiplexed digit scanning onto user IO pads.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_wrapper
    import seven_seg_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          N_DIGITS    = 4,
    parameter int          PIN_BASE    = 8,
    parameter int          SCAN_DIV    = 1000,
    parameter logic [23:0] COMPARE_RST = 24'd9999999
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int c_dw     = 4 * N_DIGITS;
    localparam int c_div_w  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIGITS - 1);
    localparam logic [37:0] c_pin_mask =
        38'(((64'd1 << (7 + N_DIGITS)) - 64'd1) << PIN_BASE);

    logic              r_ack;
    logic [31:0]       r_rdata;
    logic              r_active;
    logic              r_soft_rst;
    logic              r_direct_mode;
    logic              r_blank;
    logic [23:0]       r_compare;
    logic [c_dw-1:0]   r_direct_data;
    logic [23:0]       r_presc;
    logic [c_dw-1:0]   r_count;
    logic [c_div_w-1:0] r_div;
    logic [c_idx_w-1:0] r_idx;

    logic              w_req;
    logic              w_acc;
    logic              w_hit_ctrl;
    logic              w_hit_compare;
    logic              w_hit_direct;
    logic              w_hit_count;
    logic              w_cmp_wr;
    logic              w_core_rst;
    logic              w_tick;
    logic [31:0]       w_wmask;
    logic [31:0]       w_rdata;
    logic [c_dw-1:0]   w_count_next;
    logic              w_carry;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg_raw;
    logic [6:0]        w_seg;
    logic [N_DIGITS-1:0] w_en;
    logic              w_unused;

    assign w_req         = wbs_cyc_i & wbs_stb_i;
    assign w_acc         = w_req & ~r_ack;
    assign w_hit_ctrl    = (wbs_adr_i == ADDR_BASE + c_off_ctrl);
    assign w_hit_compare = (wbs_adr_i == ADDR_BASE + c_off_compare);
    assign w_hit_direct  = (wbs_adr_i == ADDR_BASE + c_off_direct);
    assign w_hit_count   = (wbs_adr_i == ADDR_BASE + c_off_count);
    assign w_cmp_wr      = w_acc & wbs_we_i & w_hit_compare;
    assign w_wmask       = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                            {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_core_rst    = ~wb_rst_i | r_soft_rst;
    // A COMPARE write in the match cycle wins: no tick, prescaler restarts.
    assign w_tick        = ~w_core_rst & ~w_cmp_wr & (r_presc == r_compare);

    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl)
            w_rdata = {28'd0, r_blank, r_direct_mode, r_soft_rst, r_active};
        else if (w_hit_compare)
            w_rdata = {8'd0, r_compare};
        else if (w_hit_direct)
            w_rdata = 32'(r_direct_data);
        else if (w_hit_count)
            w_rdata = 32'(r_count);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= (w_acc && !wbs_we_i) ? w_rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_active      <= 1'b0;
            r_soft_rst    <= 1'b1;
            r_direct_mode <= 1'b0;
            r_blank       <= 1'b0;
            r_compare     <= COMPARE_RST;
            r_direct_data <= '0;
        end else if (w_acc && wbs_we_i) begin
            if (w_hit_ctrl && wbs_sel_i[0]) begin
                r_active      <= wbs_dat_i[c_ctrl_active];
                r_soft_rst    <= wbs_dat_i[c_ctrl_soft_rst];
                r_direct_mode <= wbs_dat_i[c_ctrl_direct];
                r_blank       <= wbs_dat_i[c_ctrl_blank];
            end
            if (w_hit_compare)
                r_compare <= (r_compare & ~w_wmask[23:0]) |
                             (wbs_dat_i[23:0] & w_wmask[23:0]);
            if (w_hit_direct)
                r_direct_data <= (r_direct_data & ~w_wmask[c_dw-1:0]) |
                                 (wbs_dat_i[c_dw-1:0] & w_wmask[c_dw-1:0]);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_core_rst || w_cmp_wr || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 24'd1;
    end

    // Decimal ripple increment; all-9s naturally rolls over to all-0s.
    always_comb begin
        w_count_next = r_count;
        w_carry      = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_next[4*i +: 4] = 4'd0;
                end else begin
                    w_count_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_core_rst)
            r_count <= '0;
        else if (w_tick)
            r_count <= w_count_next;
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_core_rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_nibble = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i))
                w_nibble = r_direct_mode ? r_direct_data[4*i +: 4]
                                         : r_count[4*i +: 4];
        end
    end

    seven_seg_decode u_decode (
        .nibble (w_nibble),
        .seg    (w_seg_raw)
    );

    assign w_seg = r_blank ? 7'd0 : w_seg_raw;
    assign w_en  = r_blank ? '0 : (N_DIGITS'(1) << r_idx);

    assign io_out    = r_active ? (38'({w_en, w_seg}) << PIN_BASE) : '0;
    assign io_oeb    = r_active ? ~c_pin_mask : '0;
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdata;

    assign w_unused = ^{io_in, wbs_dat_i, w_wmask};

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_wrapper
// Description : Scoreboard bench for seven_seg_scan_wrapper (4 digits, scan 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_wrapper;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] rdat;
    logic [37:0] io_in, io_out, io_oeb;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_exp[$];
    bit          q_chk[$];
    string       q_name[$];

    logic [31:0] mon_exp;
    bit          mon_chk;
    string       mon_name;

    logic [37:0] oeb_on;
    int          lat;

    always #5 clk = ~clk;

    seven_seg_scan_wrapper #(
        .ADDR_BASE   (BASE),
        .N_DIGITS    (4),
        .PIN_BASE    (8),
        .SCAN_DIV    (3),
        .COMPARE_RST (24'd9999999)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand layout of the pads: segments at 8..14, enables at 15..18.
    function automatic logic [37:0] pad(input logic [3:0] en, input logic [6:0] seg);
        logic [37:0] t;
        t = '0;
        t[14:8]  = seg;
        t[18:15] = en;
        return t;
    endfunction

    always @(negedge clk) begin
        if (ack) begin
            if (q_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with data 0x%0h, required no ack", rdat);
            end else begin
                mon_exp  = q_exp.pop_front();
                mon_chk  = q_chk.pop_front();
                mon_name = q_name.pop_front();
                if (mon_chk) chk(mon_name, 64'(rdat), 64'(mon_exp));
            end
        end
    end

    // Called at posedge+1 with ack low; returns at posedge+1 one idle cycle after ack.
    task automatic wb(input logic [31:0] a, input logic [31:0] d, input bit w,
                      input logic [31:0] exp, input string name, output int l);
        q_exp.push_back(exp);
        q_chk.push_back(!w);
        q_name.push_back(name);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = 4'hF;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
        end while (!ack && l < 20);
        if (!ack) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no ack after %0d cycles, required ack", name, l);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        int l;
        wb(BASE + off, d, 1'b1, 32'd0, "write", l);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        int l;
        wb(BASE + off, 32'd0, 1'b0, exp, name, l);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] en_tab [5];
        logic [6:0] seg_tab[5];
        en_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seg_tab = '{7'h3F, 7'h71, 7'h6D, 7'h77, 7'h3F};
        oeb_on = '1;
        oeb_on[18:8] = '0;

        rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; io_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_io_out", 64'(io_out), 64'd0);
        chk("rst_io_oeb", 64'(io_oeb), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd(32'h0, 32'h2, "rst_ctrl");
        rd(32'h4, 32'h0098_967F, "rst_compare");
        rd(32'hC, 32'h0, "rst_count");
        chk("idle_io_oeb", 64'(io_oeb), 64'd0);
        chk("idle_io_out", 64'(io_out), 64'd0);

        // Count run: one tick per cycle, frozen by a huge COMPARE.
        wr(32'h4, 32'h0);
        wr(32'h0, 32'h1);
        chk("active_io_oeb", 64'(io_oeb), 64'(oeb_on));
        repeat (1233) @(posedge clk);
        #1;
        wr(32'h4, 32'hFF_FFFF);
        rd(32'hC, 32'h1234, "count_1234");
        wr(32'h4, 32'h0);
        repeat (8764) @(posedge clk);
        #1;
        wr(32'h4, 32'hFF_FFFF);
        rd(32'hC, 32'h9999, "count_9999");
        wr(32'h4, 32'h0);
        wr(32'h4, 32'hFF_FFFF);
        rd(32'hC, 32'h0, "count_wrap");

        // Direct-mode scanning from a known phase.
        wr(32'h8, 32'hA5F0);
        rd(32'h8, 32'hA5F0, "direct_rb");
        wr(32'h0, 32'h7);
        wr(32'h0, 32'h5);
        for (int s = 0; s < 5; s++) begin
            if (s != 0) begin
                repeat (3) @(posedge clk);
                #1;
            end
            chk($sformatf("scan_slot%0d", s), 64'(io_out), 64'(pad(en_tab[s], seg_tab[s])));
        end
        wr(32'h0, 32'hD);
        chk("blank_io_out", 64'(io_out), 64'd0);
        chk("blank_io_oeb", 64'(io_oeb), 64'(oeb_on));
        wr(32'h0, 32'h5);
        chk("unblank_advanced", 64'(io_out), 64'(pad(4'b0010, 7'h71)));
        wr(32'h0, 32'h4);
        chk("inactive_io_out", 64'(io_out), 64'd0);
        chk("inactive_io_oeb", 64'(io_oeb), 64'd0);

        wb(BASE + 32'h10, 32'd0, 1'b0, 32'd0, "unmapped_read", lat);
        chk("unmapped_latency", 64'(lat), 64'd1);

        // Held request: ack pulses 1,0,1 with data dropping to 0 in between.
        q_exp.push_back(32'h4); q_chk.push_back(1'b1); q_name.push_back("b2b_first");
        q_exp.push_back(32'h4); q_chk.push_back(1'b1); q_name.push_back("b2b_second");
        cyc = 1; stb = 1; we = 0; adr = BASE; sel = 4'hF;
        @(posedge clk); #1;
        chk("b2b_ack1", 64'(ack), 64'd1);
        @(posedge clk); #1;
        chk("b2b_gap_ack", 64'(ack), 64'd0);
        chk("b2b_gap_data", 64'(rdat), 64'd0);
        @(posedge clk); #1;
        chk("b2b_ack2", 64'(ack), 64'd1);
        cyc = 0; stb = 0;
        @(posedge clk); #1;

        // COMPARE rewrite lands on the match cycle: tick suppressed.
        wr(32'h0, 32'h3);
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        wr(32'h4, 32'd5);
        rd(32'hC, 32'h0, "race_no_tick");
        repeat (4) @(posedge clk);
        #1;
        rd(32'hC, 32'h1, "race_restart");

        wr(32'h0, 32'h3);
        rd(32'hC, 32'h0, "soft_rst_count");
        rd(32'h0, 32'h3, "soft_rst_ctrl");

        chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
